// File: rtl/dma_ctrl_mc.sv
// Multi-channel round-robin DMA bus master. Each element is one READ bus cycle followed by
// one WRITE bus cycle; burst mode keeps the bus between elements, single mode releases it.
module dma_ctrl_mc #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int NCH    = 2,
    parameter int LEN_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_,
    output logic [ADDR_W-1:0]     o_addr,
    output logic [DATA_W-1:0]     o_odata,
    input  logic [DATA_W-1:0]     i_idata,
    output logic                  o_rw_,
    output logic                  o_breq_,
    input  logic                  i_bgrt_,
    input  logic [NCH-1:0]        i_dreq_,
    input  logic [NCH*ADDR_W-1:0] i_dsaddr,
    input  logic [NCH*ADDR_W-1:0] i_ddaddr,
    input  logic [NCH*LEN_W-1:0]  i_dlen,
    input  logic [NCH*2-1:0]      i_dmode,
    output logic [NCH-1:0]        o_eop_,
    output logic                  o_busy
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    // state | meaning
    // IDLE  | waiting for any channel request
    // REQ   | bus requested (or re-requested after a single-mode release), waiting for grant
    // READ  | source address on the bus
    // WRITE | destination address and captured read data on the bus
    // DONE  | transfer finished; eop_ pulse and bus release on exit
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_WRITE, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CH_W-1:0]   r_rr, w_rr_nxt;
    logic [CH_W-1:0]   r_ch, w_ch_nxt;
    logic [ADDR_W-1:0] r_src, w_src_nxt;
    logic [ADDR_W-1:0] r_dst, w_dst_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
    logic [1:0]        r_mode, w_mode_nxt;
    logic [DATA_W-1:0] r_odata, w_odata_nxt;
    logic              r_rw_, w_rw_nxt;
    logic              r_breq_, w_breq_nxt;
    logic              r_busy, w_busy_nxt;
    logic [NCH-1:0]    r_eop_, w_eop_nxt;

    logic              w_found;
    int                w_sel;
    int                w_idx;
    logic [ADDR_W-1:0] w_src_inc;
    logic [ADDR_W-1:0] w_dst_inc;

    // first requesting channel at or after the round-robin pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_sel   = 0;
        w_idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = (int'(r_rr) + k) % NCH;
            if (!w_found && !i_dreq_[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_src_inc = (r_mode == 2'b10) ? r_src : r_src + ADDR_W'(1);
    assign w_dst_inc = (r_mode == 2'b11) ? r_dst : r_dst + ADDR_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_ch_nxt    = r_ch;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_odata_nxt = r_odata;
        w_rw_nxt    = r_rw_;
        w_breq_nxt  = r_breq_;
        w_busy_nxt  = r_busy;
        w_eop_nxt   = '1;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_ch_nxt   = CH_W'(w_sel);
                    w_rr_nxt   = (w_sel == NCH - 1) ? '0 : CH_W'(w_sel + 1);
                    w_src_nxt  = i_dsaddr[w_sel*ADDR_W +: ADDR_W];
                    w_dst_nxt  = i_ddaddr[w_sel*ADDR_W +: ADDR_W];
                    w_cnt_nxt  = i_dlen[w_sel*LEN_W +: LEN_W];
                    w_mode_nxt = i_dmode[w_sel*2 +: 2];
                    w_busy_nxt = 1'b1;
                    if (i_dlen[w_sel*LEN_W +: LEN_W] == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_breq_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // a released bus is re-requested for one cycle before any grant is honoured
                if (r_breq_) begin
                    w_breq_nxt = 1'b0;
                end else if (!i_bgrt_) begin
                    w_addr_nxt  = r_src;
                    w_rw_nxt    = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_odata_nxt = i_idata;
                w_addr_nxt  = r_dst;
                w_rw_nxt    = 1'b0;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_cnt_nxt = r_cnt - LEN_W'(1);
                w_src_nxt = w_src_inc;
                w_dst_nxt = w_dst_inc;
                w_rw_nxt  = 1'b1;
                if (r_cnt == LEN_W'(1)) begin
                    w_state_nxt = S_DONE;
                end else if (r_mode[0]) begin
                    if (i_bgrt_) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_addr_nxt  = w_src_inc;
                        w_state_nxt = S_READ;
                    end
                end else begin
                    w_breq_nxt  = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_DONE: begin
                w_eop_nxt[r_ch] = 1'b0;
                w_breq_nxt      = 1'b1;
                w_rw_nxt        = 1'b1;
                w_busy_nxt      = 1'b0;
                w_state_nxt     = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_ch    <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_mode  <= '0;
            r_odata <= '0;
            r_rw_   <= 1'b1;
            r_breq_ <= 1'b1;
            r_busy  <= 1'b0;
            r_eop_  <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_ch    <= w_ch_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_odata <= w_odata_nxt;
            r_rw_   <= w_rw_nxt;
            r_breq_ <= w_breq_nxt;
            r_busy  <= w_busy_nxt;
            r_eop_  <= w_eop_nxt;
        end
    end

    assign o_addr  = r_addr;
    assign o_odata = r_odata;
    assign o_rw_   = r_rw_;
    assign o_breq_ = r_breq_;
    assign o_busy  = r_busy;
    assign o_eop_  = r_eop_;

endmodule
